// File: rtl/reservation_station.sv
// Single-entry reservation station between the instruction queue and one ALU.
// Captures a control word plus operands or producer tags on load, snoops the
// CDB until both operands are known, then offers the op with valid/ready.
// Optional feature macro: RS_WAKEUP_BYPASS_EN. When it is defined, a CDB
// broadcast that resolves the last operand issues in the same cycle.
//
// state | meaning
// EMPTY | no entry held, empty=1
// WAIT  | entry held, at least one operand still waiting on the CDB
// READY | both operands known, issue_valid=1 until accepted

package tomasula_types;
    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  src1_reg;
        logic        src1_valid;
        logic [4:0]  src2_reg;
        logic        src2_valid;
        logic [31:0] src2_data;
        logic [2:0]  funct3;
        logic        funct7;
        logic [4:0]  rd;
        logic [31:0] pc;
    } ctl_word;
endpackage

module reservation_station #(
    parameter int TAG_W  = 3,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   load,
    input  tomasula_types::ctl_word control_i,
    input  logic [TAG_W-1:0]       rob_tag_i,
    input  logic                   rf1_busy,
    input  logic                   rf2_busy,
    input  logic [TAG_W-1:0]       rf1_tag,
    input  logic [TAG_W-1:0]       rf2_tag,
    input  logic [DATA_W-1:0]      rf1_data,
    input  logic [DATA_W-1:0]      rf2_data,
    input  logic                   cdb_valid,
    input  logic [TAG_W-1:0]       cdb_tag,
    input  logic [DATA_W-1:0]      cdb_data,
    output logic                   empty,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [3:0]             issue_op,
    output logic [2:0]             issue_funct3,
    output logic                   issue_funct7,
    output logic [DATA_W-1:0]      issue_a,
    output logic [DATA_W-1:0]      issue_b,
    output logic [TAG_W-1:0]       issue_tag
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] READY = 2'd2;

    logic [1:0]        state_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [TAG_W-1:0]  a_tag_q, b_tag_q;
    logic              a_rdy_q, b_rdy_q;
    logic [3:0]        op_q;
    logic [2:0]        funct3_q;
    logic              funct7_q;
    logic [TAG_W-1:0]  tag_q;

    logic [DATA_W-1:0] cap_a, cap_b;
    logic              cap_a_rdy, cap_b_rdy;
    logic              a_wake, b_wake, last_wake;

    // rd is tracked by the ROB, not needed here
    logic unused_ctl;
    assign unused_ctl = ^control_i.rd;

    // Operand A at capture: pc, x0, forwarded CDB value, regfile value or a pending tag
    always_comb begin
        cap_a     = '0;
        cap_a_rdy = 1'b1;
        if (!control_i.src1_valid) begin
            cap_a = DATA_W'(control_i.pc);
        end else if (control_i.src1_reg == 5'd0) begin
            cap_a = '0;
        end else if (rf1_busy) begin
            if (cdb_valid && (cdb_tag == rf1_tag)) begin
                cap_a = cdb_data;
            end else begin
                cap_a_rdy = 1'b0;
            end
        end else begin
            cap_a = rf1_data;
        end
    end

    // Operand B at capture: immediate first, otherwise the same regfile path as A
    always_comb begin
        cap_b     = '0;
        cap_b_rdy = 1'b1;
        if (control_i.src2_valid) begin
            cap_b = DATA_W'(control_i.src2_data);
        end else if (control_i.src2_reg == 5'd0) begin
            cap_b = '0;
        end else if (rf2_busy) begin
            if (cdb_valid && (cdb_tag == rf2_tag)) begin
                cap_b = cdb_data;
            end else begin
                cap_b_rdy = 1'b0;
            end
        end else begin
            cap_b = rf2_data;
        end
    end

    assign a_wake    = (state_q == WAIT) && !a_rdy_q && cdb_valid && (cdb_tag == a_tag_q);
    assign b_wake    = (state_q == WAIT) && !b_rdy_q && cdb_valid && (cdb_tag == b_tag_q);
    assign last_wake = (state_q == WAIT) && (a_rdy_q || a_wake) && (b_rdy_q || b_wake);

    assign empty        = (state_q == EMPTY);
    assign issue_op     = op_q;
    assign issue_funct3 = funct3_q;
    assign issue_funct7 = funct7_q;
    assign issue_tag    = tag_q;

`ifdef RS_WAKEUP_BYPASS_EN
    logic byp_fire;
    // A squash in the same cycle must not let the bypassed op escape
    assign byp_fire    = last_wake && !rst && !flush;
    assign issue_valid = (state_q == READY) || byp_fire;
    assign issue_a     = a_wake ? cdb_data : a_q;
    assign issue_b     = b_wake ? cdb_data : b_q;
`else
    assign issue_valid = (state_q == READY);
    assign issue_a     = a_q;
    assign issue_b     = b_q;
`endif

    // Entry state: capture on load, CDB wakeup in WAIT, release on handshake
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q  <= EMPTY;
            a_q      <= '0;
            b_q      <= '0;
            a_tag_q  <= '0;
            b_tag_q  <= '0;
            a_rdy_q  <= 1'b0;
            b_rdy_q  <= 1'b0;
            op_q     <= '0;
            funct3_q <= '0;
            funct7_q <= 1'b0;
            tag_q    <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (load) begin
                        a_q      <= cap_a;
                        b_q      <= cap_b;
                        a_tag_q  <= rf1_tag;
                        b_tag_q  <= rf2_tag;
                        a_rdy_q  <= cap_a_rdy;
                        b_rdy_q  <= cap_b_rdy;
                        op_q     <= control_i.op;
                        funct3_q <= control_i.funct3;
                        funct7_q <= control_i.funct7;
                        tag_q    <= rob_tag_i;
                        state_q  <= (cap_a_rdy && cap_b_rdy) ? READY : WAIT;
                    end
                end
                WAIT: begin
                    if (a_wake) begin
                        a_q     <= cdb_data;
                        a_rdy_q <= 1'b1;
                    end
                    if (b_wake) begin
                        b_q     <= cdb_data;
                        b_rdy_q <= 1'b1;
                    end
                    if (last_wake) begin
`ifdef RS_WAKEUP_BYPASS_EN
                        state_q <= issue_ready ? EMPTY : READY;
`else
                        state_q <= READY;
`endif
                    end
                end
                READY: begin
                    if (issue_ready) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios plus randomized traffic,
// checked every cycle against an entry-record model of the station.
module tb_reservation_station;
    import tomasula_types::*;

    localparam int TAG_W  = 3;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst, flush, load;
    ctl_word           control_i;
    logic [TAG_W-1:0]  rob_tag_i;
    logic              rf1_busy, rf2_busy;
    logic [TAG_W-1:0]  rf1_tag, rf2_tag;
    logic [DATA_W-1:0] rf1_data, rf2_data;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              empty, issue_valid, issue_ready;
    logic [3:0]        issue_op;
    logic [2:0]        issue_funct3;
    logic              issue_funct7;
    logic [DATA_W-1:0] issue_a, issue_b;
    logic [TAG_W-1:0]  issue_tag;

    always #5 clk = ~clk;

    reservation_station #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .load(load),
        .control_i(control_i), .rob_tag_i(rob_tag_i),
        .rf1_busy(rf1_busy), .rf2_busy(rf2_busy),
        .rf1_tag(rf1_tag), .rf2_tag(rf2_tag),
        .rf1_data(rf1_data), .rf2_data(rf2_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .empty(empty), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_funct3(issue_funct3), .issue_funct7(issue_funct7),
        .issue_a(issue_a), .issue_b(issue_b), .issue_tag(issue_tag)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Model: one entry record with per-operand known flag, value and awaited tag
    logic              m_full;
    logic              m_a_ok, m_b_ok;
    logic [DATA_W-1:0] m_a, m_b;
    logic [TAG_W-1:0]  m_a_tag, m_b_tag;
    logic [3:0]        m_op;
    logic [2:0]        m_f3;
    logic              m_f7;
    logic [TAG_W-1:0]  m_tag;
    logic              exp_valid;

    task automatic model_clear();
        m_full = 0; m_a_ok = 0; m_b_ok = 0; m_a = '0; m_b = '0;
        m_a_tag = '0; m_b_tag = '0; m_op = '0; m_f3 = '0; m_f7 = 0; m_tag = '0;
    endtask

    function automatic logic cdb_hits(input logic [TAG_W-1:0] t);
        return cdb_valid && (cdb_tag == t);
    endfunction

    // Compare DUT outputs against the model for the inputs currently applied
    task automatic settle();
        logic a_w, b_w;
        logic [DATA_W-1:0] ea, eb;
        @(negedge clk);
        a_w = m_full && !m_a_ok && cdb_hits(m_a_tag);
        b_w = m_full && !m_b_ok && cdb_hits(m_b_tag);
        exp_valid = m_full && m_a_ok && m_b_ok;
        ea = m_a;
        eb = m_b;
`ifdef RS_WAKEUP_BYPASS_EN
        if (!exp_valid && m_full && (m_a_ok || a_w) && (m_b_ok || b_w) && !rst && !flush) begin
            exp_valid = 1;
            if (a_w) ea = cdb_data;
            if (b_w) eb = cdb_data;
        end
`endif
        check("empty", 64'(empty), 64'(!m_full));
        check("issue_valid", 64'(issue_valid), 64'(exp_valid));
        if (exp_valid) begin
            check("issue_a", 64'(issue_a), 64'(ea));
            check("issue_b", 64'(issue_b), 64'(eb));
            check("issue_tag", 64'(issue_tag), 64'(m_tag));
            check("issue_op", 64'(issue_op), 64'(m_op));
            check("issue_funct3", 64'(issue_funct3), 64'(m_f3));
            check("issue_funct7", 64'(issue_funct7), 64'(m_f7));
        end
    endtask

    // Advance the model across the clock edge using the applied inputs
    task automatic tick();
        logic a_w, b_w;
        @(posedge clk);
        if (rst || flush) begin
            model_clear();
        end else if (!m_full) begin
            if (load) begin
                m_full = 1;
                m_op = control_i.op; m_f3 = control_i.funct3; m_f7 = control_i.funct7;
                m_tag = rob_tag_i;
                m_a_tag = rf1_tag; m_b_tag = rf2_tag;
                m_a_ok = 1; m_b_ok = 1;
                if (!control_i.src1_valid) m_a = control_i.pc;
                else if (control_i.src1_reg == 0) m_a = 0;
                else if (!rf1_busy) m_a = rf1_data;
                else if (cdb_hits(rf1_tag)) m_a = cdb_data;
                else m_a_ok = 0;
                if (control_i.src2_valid) m_b = control_i.src2_data;
                else if (control_i.src2_reg == 0) m_b = 0;
                else if (!rf2_busy) m_b = rf2_data;
                else if (cdb_hits(rf2_tag)) m_b = cdb_data;
                else m_b_ok = 0;
            end
        end else begin
            a_w = !m_a_ok && cdb_hits(m_a_tag);
            b_w = !m_b_ok && cdb_hits(m_b_tag);
            if (a_w) begin m_a = cdb_data; m_a_ok = 1; end
            if (b_w) begin m_b = cdb_data; m_b_ok = 1; end
            if (exp_valid && issue_ready) m_full = 0;
        end
        #1;
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    function automatic ctl_word mk(input logic [3:0] op, input logic s1v, input logic [4:0] s1r,
                                   input logic s2v, input logic [4:0] s2r, input logic [31:0] imm,
                                   input logic [31:0] pc);
        ctl_word c;
        c = '0;
        c.op = op; c.src1_valid = s1v; c.src1_reg = s1r;
        c.src2_valid = s2v; c.src2_reg = s2r; c.src2_data = imm;
        c.funct3 = 3'd5; c.funct7 = 1'b1; c.rd = 5'd7; c.pc = pc;
        return c;
    endfunction

    task automatic idle_inputs();
        rst = 0; flush = 0; load = 0; control_i = '0; rob_tag_i = '0;
        rf1_busy = 0; rf2_busy = 0; rf1_tag = '0; rf2_tag = '0;
        rf1_data = '0; rf2_data = '0; cdb_valid = 0; cdb_tag = '0; cdb_data = '0;
        issue_ready = 0;
    endtask

    initial begin
        logic [95:0] r;
        model_clear();
        exp_valid = 0;
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;

        // Reset then idle
        check("rst_issue_a", 64'(issue_a), 64'd0);
        check("rst_issue_b", 64'(issue_b), 64'd0);
        check("rst_issue_tag", 64'(issue_tag), 64'd0);
        check("rst_issue_op", 64'({issue_op, issue_funct3, issue_funct7}), 64'd0);
        for (int i = 0; i < 10; i++) begin
            settle();
            check("idle_empty", 64'(empty), 64'd1);
            check("idle_valid", 64'(issue_valid), 64'd0);
            tick();
        end

        // Load while in reset is dropped
        rst = 1; load = 1;
        control_i = mk(4'd1, 1'b1, 5'd5, 1'b1, 5'd0, 32'h4, 32'h100);
        tick();
        rst = 0; load = 0;
        settle();
        check("rst_load_empty", 64'(empty), 64'd1);
        tick();

        // ADDI: x5 ready with 0x10, imm 4, tag 2; backpressure for 3 cycles
        load = 1; control_i = mk(4'd1, 1'b1, 5'd5, 1'b1, 5'd0, 32'h4, 32'h100);
        rf1_data = 32'h10; rob_tag_i = 3'd2;
        cycle();
        load = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("addi_valid", 64'(issue_valid), 64'd1);
            check("addi_a", 64'(issue_a), 64'h10);
            check("addi_b", 64'(issue_b), 64'h4);
            check("addi_tag", 64'(issue_tag), 64'd2);
            tick();
        end
        issue_ready = 1;
        cycle();
        issue_ready = 0;
        settle();
        check("addi_empty_after", 64'(empty), 64'd1);
        tick();

        // ADD: both sources busy (tags 3 and 5), woken by two broadcasts
        load = 1; control_i = mk(4'd0, 1'b1, 5'd6, 1'b0, 5'd7, 32'h0, 32'h200);
        rf1_busy = 1; rf1_tag = 3'd3; rf2_busy = 1; rf2_tag = 3'd5; rob_tag_i = 3'd6;
        cycle();
        load = 0; rf1_busy = 0; rf2_busy = 0;
        cdb_valid = 1; cdb_tag = 3'd5; cdb_data = 32'hAA;
        settle();
        check("add_wait_valid", 64'(issue_valid), 64'd0);
        tick();
        cdb_tag = 3'd3; cdb_data = 32'h55;
        settle();
`ifdef RS_WAKEUP_BYPASS_EN
        check("add_bypass_valid", 64'(issue_valid), 64'd1);
        check("add_bypass_a", 64'(issue_a), 64'h55);
`else
        check("add_nobypass_valid", 64'(issue_valid), 64'd0);
`endif
        tick();
        cdb_valid = 0;
        settle();
        check("add_valid", 64'(issue_valid), 64'd1);
        check("add_a", 64'(issue_a), 64'h55);
        check("add_b", 64'(issue_b), 64'hAA);
        tick();
        issue_ready = 1;
        cycle();
        issue_ready = 0;

        // Load-cycle CDB forward on a busy source
        load = 1; control_i = mk(4'd2, 1'b1, 5'd9, 1'b1, 5'd0, 32'h8, 32'h300);
        rf1_busy = 1; rf1_tag = 3'd4; rob_tag_i = 3'd1;
        cdb_valid = 1; cdb_tag = 3'd4; cdb_data = 32'h77;
        cycle();
        load = 0; rf1_busy = 0; cdb_valid = 0;
        settle();
        check("fwd_valid", 64'(issue_valid), 64'd1);
        check("fwd_a", 64'(issue_a), 64'h77);
        tick();
        issue_ready = 1;
        cycle();
        issue_ready = 0;

        // Flush in WAIT alongside a matching broadcast
        load = 1; control_i = mk(4'd3, 1'b1, 5'd3, 1'b1, 5'd0, 32'h1, 32'h400);
        rf1_busy = 1; rf1_tag = 3'd6;
        cycle();
        load = 0; rf1_busy = 0;
        flush = 1; cdb_valid = 1; cdb_tag = 3'd6; cdb_data = 32'h33;
        settle();
        check("flush_no_issue", 64'(issue_valid), 64'd0);
        tick();
        flush = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("flush_empty", 64'(empty), 64'd1);
            check("flush_late_cdb", 64'(issue_valid), 64'd0);
            tick();
        end
        cdb_valid = 0;

        // x0 marked busy is still zero and ignores the CDB
        load = 1; control_i = mk(4'd4, 1'b1, 5'd0, 1'b1, 5'd0, 32'h2, 32'h500);
        rf1_busy = 1; rf1_tag = 3'd1;
        cycle();
        load = 0; rf1_busy = 0;
        cdb_valid = 1; cdb_tag = 3'd1; cdb_data = 32'h99;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("x0_valid", 64'(issue_valid), 64'd1);
            check("x0_a", 64'(issue_a), 64'd0);
            tick();
        end
        cdb_valid = 0; issue_ready = 1;
        cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            r = {$urandom, $urandom, $urandom};
            control_i = r[88:0];
            control_i.src1_reg = 5'($urandom_range(0, 3));
            control_i.src2_reg = 5'($urandom_range(0, 3));
            rst         = ($urandom_range(0, 99) == 0);
            flush       = ($urandom_range(0, 39) == 0);
            load        = $urandom_range(0, 1) == 1;
            rob_tag_i   = 3'($urandom);
            rf1_busy    = $urandom_range(0, 1) == 1;
            rf2_busy    = $urandom_range(0, 1) == 1;
            rf1_tag     = 3'($urandom);
            rf2_tag     = 3'($urandom);
            rf1_data    = $urandom;
            rf2_data    = $urandom;
            cdb_valid   = $urandom_range(0, 1) == 1;
            cdb_tag     = 3'($urandom);
            cdb_data    = $urandom;
            issue_ready = $urandom_range(0, 2) != 0;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
# reservation_station

Single-entry reservation station that sits directly downstream of the instruction queue. It accepts one dequeued control word when its load strobe is asserted and captures operand values or producer tags from the register file. It snoops the common data bus (CDB) until both operands are available, then presents a complete operation to its ALU with a valid/ready handshake. It reports `empty` back to the instruction queue, which routes instructions to the lowest-numbered empty station.

## Interface
Parameters:
- `TAG_W`, 3: ROB tag width (8-entry ROB).
- `DATA_W`, 32: operand/result width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: squash the held entry; same effect as reset.
- `load` in 1: capture `control_i` this cycle (driven by the queue's `resN_load`).
- `control_i` in `tomasula_types::ctl_word`: op, src1_reg/valid, src2_reg/valid, src2_data, funct3, funct7, rd, pc.
- `rob_tag_i` in TAG_W: destination tag allocated by the ROB in the load cycle.
- `rf1_busy`, `rf2_busy` in 1: source register awaits a producer.
- `rf1_tag`, `rf2_tag` in TAG_W: producer tag when busy.
- `rf1_data`, `rf2_data` in DATA_W: register value when not busy.
- `cdb_valid` in 1; `cdb_tag` in TAG_W; `cdb_data` in DATA_W: result broadcast.
- `empty` out 1: station holds no entry.
- `issue_valid` out 1: operation ready for the ALU.
- `issue_ready` in 1: ALU accepts this cycle.
- `issue_op` out 4; `issue_funct3` out 3; `issue_funct7` out 1.
- `issue_a`, `issue_b` out DATA_W: operands.
- `issue_tag` out TAG_W: destination ROB tag.

## Operation
- States: EMPTY, WAIT, READY.
- EMPTY + `load` goes to READY if both operands are resolved at capture, otherwise WAIT. `load` in WAIT/READY is ignored.
- Operand A:
  - `src1_valid`=0: A = `pc`, resolved.
  - `src1_reg`=0: A = 0, resolved.
  - Otherwise, if `rf1_busy`, store `rf1_tag` unresolved; else store `rf1_data`.
- Operand B:
  - `src2_valid`=1: B = `src2_data` (immediate), resolved.
  - Otherwise use the regfile path as for A: `rf2_*`, with x0 giving 0.
- Load-cycle CDB match: if `cdb_valid` and `cdb_tag` equals a busy rf tag, capture `cdb_data` and mark the operand resolved. This applies in all configurations.
- WAIT: each cycle, every unresolved operand whose tag equals `cdb_tag` with `cdb_valid` set captures `cdb_data`. Both operands may wake on one broadcast. Transition to READY when both are resolved.
- READY: `issue_valid`=1. `issue_valid & issue_ready` goes to EMPTY.
- `empty` = (state == EMPTY). It is a state decode only, so no same-cycle refill after issue.
- `flush` or `rst` go to EMPTY and clear the resolved flags. Flush has priority over load, wakeup, and issue in the same cycle.
- `issue_*` data outputs are held stable while `issue_valid`=1 and not accepted.

## Timing
- Reset values: `empty`=1, `issue_valid`=0, `issue_a`/`issue_b`=0, `issue_tag`=0, `issue_op`/`issue_funct3`/`issue_funct7`=0.
- Load with both operands resolved at edge N gives `issue_valid`=1 in cycle N+1.
- CDB wakeup of the last operand in cycle M (no bypass) gives `issue_valid` in M+1.
- Issue handshake completes on the edge where `issue_valid & issue_ready`. `empty`=1 the following cycle.
- Minimum occupancy is 1 cycle; throughput is one op per 2 cycles per station.
- A CDB tag matching neither operand, or arriving in EMPTY/READY, has no effect.

## Configuration
- `RS_WAKEUP_BYPASS_EN` defined:
  - In WAIT, if the CDB broadcast resolves the last operand, `issue_valid` asserts combinationally that cycle.
  - The matching `issue_a`/`issue_b` is muxed from `cdb_data`.
  - If `issue_ready` is also high, the station goes straight to EMPTY.
- Macro undefined:
  - `issue_valid` is purely a decode of READY.
  - All `issue_*` outputs are register outputs; wakeup-to-issue latency is 1 cycle.

## Test plan
- Reset then idle: `empty`=1, `issue_valid`=0 for 10 cycles. Assert `load` with `rst`=1: still EMPTY next cycle.
- ADDI: load x5 (not busy, data 0x10) with imm 0x4, `rob_tag_i`=2 → next cycle `issue_valid`=1, a=0x10, b=0x4, tag=2. Hold `issue_ready`=0 for 3 cycles: outputs stable. Then ready=1 → `empty`=1.
- ADD: both sources busy with tags 3 and 5. CDB tag 5 data 0xAA, then tag 3 data 0x55 → `issue_valid` one cycle after the tag-3 broadcast (same cycle with bypass); a=0x55, b=0xAA.
- Load with `rf1_busy` tag 4 while CDB broadcasts tag 4 data 0x77 in the same cycle → a=0x77, no WAIT; `issue_valid` next cycle.
- In WAIT, assert `flush` together with a matching CDB → EMPTY next cycle, no issue. A later broadcast of the same tag has no effect.
- Source x0 marked busy with tag 1 → a=0, resolved. A CDB broadcast of tag 1 does not alter a.
